// File: rtl/ascii_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ascii_operand_loader_if
// Brief    : Character stream in, operand pair out, for the ASCII loader.
// Revision : 1.0 - initial release
// ============================================================================
interface ascii_operand_loader_if #(
  parameter int W = 5
);
  logic [7:0]   char_in;
  logic         char_valid;
  logic         char_ready;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         operands_valid;
  logic         operands_ack;
  logic         ovf_x;
  logic         ovf_y;
  logic         err;

  // master: character source and operand consumer; slave: the loader itself
  modport master (
    output char_in, char_valid, operands_ack,
    input  char_ready, X, Y, operands_valid, ovf_x, ovf_y, err
  );
  modport slave (
    input  char_in, char_valid, operands_ack,
    output char_ready, X, Y, operands_valid, ovf_x, ovf_y, err
  );
endinterface
`default_nettype wire

// File: rtl/ascii_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : ascii_operand_loader
// Brief    : Parses two Enter-terminated decimal numbers into operands X/Y.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_operand_loader #(
  parameter int W          = 5,
  parameter int MAX_DIGITS = 2
) (
  input  wire logic            clk,
  input  wire logic            reset,
  ascii_operand_loader_if.slave bus
);
  localparam int c_ACC_W = $clog2(10**MAX_DIGITS);
  localparam int c_CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    GET_X = 2'd0,
    GET_Y = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_ACC_W-1:0]   r_acc;
  logic [c_CNT_W-1:0]   r_digit_cnt;
  logic [W-1:0]         r_x;
  logic [W-1:0]         r_y;
  logic                 r_ovf_x;
  logic                 r_ovf_y;
  logic                 r_valid;
  logic                 r_ready;
  logic                 r_err;

  logic                 w_fire;
  logic                 w_is_digit;
  logic                 w_is_term;
  logic                 w_cnt_full;
  logic                 w_ovf;
  logic [c_ACC_W-1:0]   w_acc_next;
  logic [W-1:0]         w_val;

  assign w_fire     = bus.char_valid && r_ready;
  assign w_is_digit = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
  assign w_is_term  = (bus.char_in == 8'h0A) || (bus.char_in == 8'h0D);
  assign w_cnt_full = (32'(r_digit_cnt) >= MAX_DIGITS);
  // acc stays below 10^(MAX_DIGITS-1) while accumulating, so this never wraps
  assign w_acc_next = (r_acc * c_ACC_W'(10)) + c_ACC_W'(bus.char_in - 8'h30);
  assign w_ovf      = 32'(r_acc) > ((32'd1 << W) - 32'd1);
  assign w_val      = W'(r_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= GET_X;
      r_acc       <= '0;
      r_digit_cnt <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_ovf_x     <= 1'b0;
      r_ovf_y     <= 1'b0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        GET_X, GET_Y: begin
          if (w_fire) begin
            if (w_is_digit && !w_cnt_full) begin
              r_acc       <= w_acc_next;
              r_digit_cnt <= r_digit_cnt + c_CNT_W'(1);
            end else if (w_is_term && (r_digit_cnt != '0)) begin
              r_acc       <= '0;
              r_digit_cnt <= '0;
              if (r_state == GET_X) begin
                r_x     <= w_val;
                r_ovf_x <= w_ovf;
                r_state <= GET_Y;
              end else begin
                r_y     <= w_val;
                r_ovf_y <= w_ovf;
                r_valid <= 1'b1;
                r_ready <= 1'b0;
                r_state <= HOLD;
              end
            end else begin
              r_acc       <= '0;
              r_digit_cnt <= '0;
              r_err       <= 1'b1;
              r_state     <= ERR;
            end
          end
        end
        HOLD: begin
          if (bus.operands_ack) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= GET_X;
          end
        end
        ERR: begin
          if (w_fire && w_is_term) begin
            r_err   <= 1'b0;
            r_state <= GET_X;
          end
        end
        default: r_state <= GET_X;
      endcase
    end
  end

  assign bus.char_ready     = r_ready;
  assign bus.X              = r_x;
  assign bus.Y              = r_y;
  assign bus.ovf_x          = r_ovf_x;
  assign bus.ovf_y          = r_ovf_y;
  assign bus.operands_valid = r_valid;
  assign bus.err            = r_err;
endmodule
`default_nettype wire

// File: tb/tb_ascii_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_operand_loader
// Brief    : Scoreboard bench for ascii_operand_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_operand_loader;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ascii_operand_loader_if #(.W(5)) bus();
  ascii_operand_loader #(.W(5), .MAX_DIGITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int ox;
    int oy;
  } pair_t;

  pair_t sb[$];
  pair_t r_exp;
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    t0;
  logic  prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every rising edge of operands_valid must match the oldest queued pair
  always @(negedge clk) begin
    if (bus.operands_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        r_exp = sb.pop_front();
        check("sb_x",     32'(bus.X), r_exp.x);
        check("sb_y",     32'(bus.Y), r_exp.y);
        check("sb_ovf_x", 32'(bus.ovf_x), r_exp.ox);
        check("sb_ovf_y", 32'(bus.ovf_y), r_exp.oy);
      end
    end
    prev_valid <= bus.operands_valid;
  end

  task automatic send_char(input byte c, input int gap = 0);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    while (!bus.char_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap = 0);
    for (int i = 0; i < s.len(); i++) send_char(s[i], gap);
  endtask

  task automatic expect_pair(input int x, input int y, input int ox, input int oy);
    sb.push_back('{x, y, ox, oy});
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.operands_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.operands_ack = 1'b0;
    check("ack_valid", 32'(bus.operands_valid), 0);
    check("ack_ready", 32'(bus.char_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.char_in      = 8'h00;
    bus.char_valid   = 1'b0;
    bus.operands_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(bus.char_ready), 1);
    check("rst_x",     32'(bus.X), 0);
    check("rst_y",     32'(bus.Y), 0);
    check("rst_valid", 32'(bus.operands_valid), 0);
    check("rst_ovf",   32'({bus.ovf_x, bus.ovf_y}), 0);
    check("rst_err",   32'(bus.err), 0);

    // Basic pair at full rate, then held without ack while a char is offered
    expect_pair(7, 25, 0, 0);
    t0 = cyc;
    send_str("07\n25\n");
    check("latency", cyc - t0, 6);
    check("basic_valid", 32'(bus.operands_valid), 1);
    @(negedge clk);
    bus.char_in    = "9";
    bus.char_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ready", 32'(bus.char_ready), 0);
      check("hold_valid", 32'(bus.operands_valid), 1);
      check("hold_x",     32'(bus.X), 7);
      check("hold_y",     32'(bus.Y), 25);
    end
    bus.char_valid = 1'b0;
    do_ack();

    // Overflow, single digit, CR terminator, and the top of range
    expect_pair(8, 9, 1, 0);
    send_str("40\n9\r");
    do_ack();
    expect_pair(31, 31, 0, 0);
    send_str("31\n31\n");
    do_ack();

    // Too many digits: err on the third digit, held until a terminator
    send_str("12");
    check("err_pre", 32'(bus.err), 0);
    send_char("3");
    check("err_on_3", 32'(bus.err), 1);
    check("err_ready", 32'(bus.char_ready), 1);
    send_char("7");
    check("err_discard", 32'(bus.err), 1);
    send_char(8'h0A);
    check("err_exit", 32'(bus.err), 0);

    // Illegal character, then a clean pair
    send_str("5a");
    check("err_illegal", 32'(bus.err), 1);
    send_char(8'h0A);
    check("err_exit2", 32'(bus.err), 0);
    expect_pair(1, 2, 0, 0);
    send_str("01\n02\n");
    do_ack();

    // Empty number enters ERR but does not exit it
    send_char(8'h0A);
    check("err_empty_x", 32'(bus.err), 1);
    send_char(8'h0D);
    check("err_exit3", 32'(bus.err), 0);

    // Empty Y after a good X: no valid, restart from X
    send_str("4\n\n");
    check("err_empty_y", 32'(bus.err), 1);
    check("err_no_valid", 32'(bus.operands_valid), 0);
    send_char(8'h0A);
    check("err_exit4", 32'(bus.err), 0);
    expect_pair(6, 7, 0, 0);
    send_str("06\n07\n");
    do_ack();

    // Throttled source
    expect_pair(12, 13, 0, 0);
    send_str("12\n13\n", 1);
    do_ack();

    // Reset on Y's second digit
    send_str("03\n1");
    @(negedge clk);
    bus.char_in    = "2";
    bus.char_valid = 1'b1;
    reset          = 1'b1;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    reset          = 1'b0;
    check("mid_rst_x",     32'(bus.X), 0);
    check("mid_rst_y",     32'(bus.Y), 0);
    check("mid_rst_valid", 32'(bus.operands_valid), 0);
    check("mid_rst_err",   32'(bus.err), 0);
    check("mid_rst_ready", 32'(bus.char_ready), 1);
    expect_pair(3, 4, 0, 0);
    send_str("03\n04\n");
    do_ack();

    // Downstream 5-bit adder: 20 + 15 = 35 -> sum 3, carry 1
    expect_pair(20, 15, 0, 0);
    send_str("20\n15\n");
    begin
      logic [5:0] w_sum;
      w_sum = {1'b0, bus.X} + {1'b0, bus.Y};
      check("adder_valid", 32'(bus.operands_valid), 1);
      check("adder_sum",   32'(w_sum[4:0]), 3);
      check("adder_cout",  32'(w_sum[5]), 1);
    end
    do_ack();

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
